// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone classic-cycle burst initiator. Takes burst commands
// from a valid/ready port, fetches write words from a stream, and issues one
// strobed beat per word at incrementing addresses. A beat that waits too long
// for its ack aborts the rest of the burst and flags an error.
module wb_burst_master #(
   parameter int AW      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [7:0]    cmd_len,
   input  logic [3:0]    cmd_sel,
   input  logic          wdat_valid,
   output logic          wdat_ready,
   input  logic [31:0]   wdat,
   output logic          rdat_valid,
   output logic [31:0]   rdat,
   output logic          done,
   output logic          err,
   output logic          busy,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic          wb_we_o,
   output logic [3:0]    wb_sel_o,
   output logic [AW-1:0] wb_adr_o,
   output logic [31:0]   wb_dat_o,
   input  logic          wb_ack_i,
   input  logic [31:0]   wb_dat_i
);

   typedef enum logic [2:0] {S_IDLE, S_WDAT, S_STB, S_GAP, S_DONE} state_t;

   // The wait counter leaves STB as soon as it reaches TIMEOUT-1, so it
   // never needs to hold TIMEOUT itself.
   localparam int            TW      = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   state_t        state;
   state_t        state_nxt;
   logic          we_q;
   logic [3:0]    sel_q;
   logic [AW-1:0] adr_q;
   logic [31:0]   dat_q;
   logic [7:0]    beat_cnt;
   logic [TW-1:0] to_cnt;
   logic          err_q;
   logic          cmd_acc;
   logic          ack_stb;
   logic          to_hit;

   assign cmd_acc = (state == S_IDLE) && cmd_valid;
   assign ack_stb = (state == S_STB) && wb_ack_i;
   // An ack in the last allowed cycle still wins over the timeout.
   assign to_hit  = (state == S_STB) && !wb_ack_i && (to_cnt == TO_LAST);

   assign wb_we_o  = we_q;
   assign wb_sel_o = sel_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;

   // State register.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (cmd_valid) state_nxt = cmd_we ? S_WDAT : S_STB;
         S_WDAT: if (wdat_valid) state_nxt = S_STB;
         S_STB: begin
            if (wb_ack_i)    state_nxt = (beat_cnt == 8'd0) ? S_DONE : S_GAP;
            else if (to_hit) state_nxt = S_DONE;
         end
         S_GAP:   state_nxt = we_q ? S_WDAT : S_STB;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control outputs decoded from the current state.
   always_comb begin
      cmd_ready  = (state == S_IDLE);
      busy       = (state != S_IDLE);
      wdat_ready = (state == S_WDAT);
      wb_stb_o   = (state == S_STB);
      wb_cyc_o   = (state == S_WDAT) || (state == S_STB) || (state == S_GAP);
      done       = (state == S_DONE);
      err        = (state == S_DONE) && err_q;
   end

   // Burst context: direction, lanes, beat address/count, write word, error.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         we_q     <= 1'b0;
         sel_q    <= 4'd0;
         adr_q    <= '0;
         dat_q    <= 32'd0;
         beat_cnt <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         if (cmd_acc) begin
            we_q     <= cmd_we;
            sel_q    <= cmd_sel;
            adr_q    <= cmd_addr & ~AW'(3);
            beat_cnt <= cmd_len;
            err_q    <= 1'b0;
         end
         if ((state == S_WDAT) && wdat_valid) dat_q <= wdat;
         if (ack_stb && (beat_cnt != 8'd0)) begin
            beat_cnt <= beat_cnt - 8'd1;
            adr_q    <= adr_q + AW'(4);
         end
         if (to_hit) err_q <= 1'b1;
      end
   end

   // Ack wait counter: restarts whenever the strobe is not up.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)            to_cnt <= '0;
      else if (state != S_STB) to_cnt <= '0;
      else                     to_cnt <= to_cnt + TW'(1);
   end

   // Read return: capture the slave word on ack and pulse valid next cycle.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rdat_valid <= 1'b0;
         rdat       <= 32'd0;
      end else begin
         rdat_valid <= ack_stb && !we_q;
         if (ack_stb && !we_q) rdat <= wb_dat_i;
      end
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: randomized bursts against a Wishbone slave with random
// wait states, spurious acks and write-stream stalls; expected beats, data and
// burst timing come from a plain reference model of the burst rules.
module tb_wb_burst_master;
   localparam int AW      = 32;
   localparam int TIMEOUT = 16;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic [3:0]    cmd_sel;
   logic          wdat_valid, wdat_ready;
   logic [31:0]   wdat;
   logic          rdat_valid;
   logic [31:0]   rdat;
   logic          done, err, busy;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]    wb_sel_o;
   logic [AW-1:0] wb_adr_o;
   logic [31:0]   wb_dat_o;
   logic          wb_ack_i;
   logic [31:0]   wb_dat_i;

   int n_chk  = 0;
   int n_pass = 0;

   // Per-beat plan: slave wait cycles, write-stream stall cycles, write words.
   int          g_dly   [257];
   int          g_stall [257];
   logic [31:0] g_wd    [257];

   logic [31:0] slv_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   always #5 wb_clk_i = ~wb_clk_i;

   wb_burst_master #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_sel   (cmd_sel),
      .wdat_valid(wdat_valid),
      .wdat_ready(wdat_ready),
      .wdat      (wdat),
      .rdat_valid(rdat_valid),
      .rdat      (rdat),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_we_o   (wb_we_o),
      .wb_sel_o  (wb_sel_o),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_i  (wb_ack_i),
      .wb_dat_i  (wb_dat_i)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Contents of a never-written slave word.
   function automatic logic [31:0] fill(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
      return m;
   endfunction

   task automatic rand_plan(input int len);
      for (int i = 0; i <= len; i++) begin
         g_dly[i]   = ($urandom % 10 == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
         g_stall[i] = ($urandom % 4 == 0) ? int'($urandom_range(1, 6)) : 0;
         g_wd[i]    = $urandom;
      end
   endtask

   task automatic drive_idle();
      cmd_valid  = 1'b0;
      wdat_valid = 1'b0;
      wdat       = 32'd0;
      wb_ack_i   = 1'b0;
      wb_dat_i   = 32'd0;
   endtask

   // dead_at >= 0: slave never acks that beat. rst_at >= 0: reset pulsed
   // mid-cycle while that beat is strobed.
   task automatic run_burst(input bit we, input logic [31:0] addr, input int len,
                            input logic [3:0] sel, input int dead_at, input int rst_at);
      logic [31:0] base, a, m, old;
      logic [31:0] e_adr[$], e_dat[$], got_adr[$], got_dat[$], got_rd[$];
      logic [3:0]  got_sel[$];
      logic        got_we[$];
      int          nbeats, exp_cyc, exp_stb, exp_cons, gaps;
      int          cyc, n_stb, n_cons, cyc_drop, w, bidx, fidx, fstall;
      bit          dead, got_err, seen_done, any_done;

      // Reference model of the whole burst.
      dead    = (dead_at >= 0);
      base    = addr & 32'hFFFF_FFFC;
      nbeats  = dead ? dead_at : len + 1;
      exp_cyc = 0;
      exp_stb = 0;
      for (int i = 0; i < nbeats; i++) begin
         a = base + 32'(4 * i);
         e_adr.push_back(a);
         if (we) begin
            m   = lane_mask(sel);
            old = ref_mem.exists(a) ? ref_mem[a] : fill(a);
            ref_mem[a] = (old & ~m) | (g_wd[i] & m);
            e_dat.push_back(g_wd[i]);
            exp_cyc += g_stall[i] + 1;
         end else begin
            e_dat.push_back(ref_mem.exists(a) ? ref_mem[a] : fill(a));
         end
         exp_cyc += g_dly[i] + 1;
         exp_stb += g_dly[i] + 1;
      end
      if (dead) begin
         exp_cyc += TIMEOUT + (we ? g_stall[dead_at] + 1 : 0);
         exp_stb += TIMEOUT;
         gaps     = nbeats;
      end else begin
         gaps = len;
      end
      exp_cyc += gaps + 1;
      exp_cons = we ? (dead ? nbeats + 1 : nbeats) : 0;

      @(negedge wb_clk_i);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = addr;
      cmd_len   = 8'(len);
      cmd_sel   = sel;
      check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      cmd_we    = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_len   = 8'($urandom);
      cmd_sel   = 4'($urandom);

      cyc = 0; n_stb = 0; n_cons = 0; cyc_drop = 0; w = 0; bidx = 0; fidx = 0;
      fstall = g_stall[0]; seen_done = 0; got_err = 0;
      while (!seen_done && cyc < 4000) begin
         cyc++;
         if (rst_at >= 0 && bidx == rst_at && wb_stb_o) begin
            #2 wb_rst_i = 1'b1;
            #1;
            check("rst_async_bus", 64'({wb_cyc_o, wb_stb_o, done, busy, rdat_valid, wdat_ready}), 64'(0));
            check("rst_async_ready", 64'(cmd_ready), 64'(1));
            check("rst_async_adr", 64'(wb_adr_o), 64'(0));
            check("rst_async_rdat", 64'(rdat), 64'(0));
            drive_idle();
            @(negedge wb_clk_i);
            wb_rst_i = 1'b0;
            any_done = 0;
            for (int k = 0; k < 4; k++) begin
               @(negedge wb_clk_i);
               if (done) any_done = 1;
            end
            check("no_done_after_rst", 64'(any_done), 64'(0));
            check("ready_after_rst", 64'(cmd_ready), 64'(1));
            return;
         end
         // Monitor.
         if (rdat_valid) got_rd.push_back(rdat);
         if (wb_stb_o) n_stb++;
         if (!wb_cyc_o && !done) cyc_drop++;
         if (done) begin
            seen_done = 1;
            got_err   = err;
         end
         // Slave.
         wb_ack_i = 1'b0;
         wb_dat_i = $urandom;
         if (wb_stb_o) begin
            if (!(dead && bidx == dead_at) && bidx <= 256 && w == g_dly[bidx]) begin
               wb_ack_i = 1'b1;
               got_adr.push_back(wb_adr_o);
               got_we.push_back(wb_we_o);
               got_sel.push_back(wb_sel_o);
               old = slv_mem.exists(wb_adr_o) ? slv_mem[wb_adr_o] : fill(wb_adr_o);
               if (wb_we_o) begin
                  got_dat.push_back(wb_dat_o);
                  m = lane_mask(wb_sel_o);
                  slv_mem[wb_adr_o] = (old & ~m) | (wb_dat_o & m);
               end else begin
                  wb_dat_i = old;
               end
               w = 0;
               bidx++;
            end else begin
               w++;
            end
         end else begin
            w = 0;
            if ($urandom % 4 == 0) wb_ack_i = 1'b1;
         end
         // Write-word source.
         if (we && wdat_ready && fidx <= len) begin
            if (fstall > 0) begin
               wdat_valid = 1'b0;
               wdat       = $urandom;
               fstall--;
            end else begin
               wdat_valid = 1'b1;
               wdat       = g_wd[fidx];
               fidx++;
               fstall = (fidx <= len) ? g_stall[fidx] : 0;
            end
         end else begin
            wdat_valid = 1'($urandom);
            wdat       = $urandom;
         end
         if (wdat_valid && wdat_ready) n_cons++;
         @(negedge wb_clk_i);
      end
      drive_idle();

      check("done_seen", 64'(seen_done), 64'(1));
      check("err_flag", 64'(got_err), 64'(dead));
      check("burst_cycles", 64'(cyc), 64'(exp_cyc));
      check("stb_cycles", 64'(n_stb), 64'(exp_stb));
      check("wdat_consumed", 64'(n_cons), 64'(exp_cons));
      check("cyc_held", 64'(cyc_drop), 64'(0));
      check("beat_count", 64'(got_adr.size()), 64'(nbeats));
      for (int i = 0; i < got_adr.size() && i < nbeats; i++) begin
         check($sformatf("beat%0d_adr", i), 64'(got_adr[i]), 64'(e_adr[i]));
         check($sformatf("beat%0d_we", i), 64'(got_we[i]), 64'(we));
         check($sformatf("beat%0d_sel", i), 64'(got_sel[i]), 64'(sel));
         if (we && i < got_dat.size())
            check($sformatf("beat%0d_wdat", i), 64'(got_dat[i]), 64'(e_dat[i]));
      end
      check("rdat_count", 64'(got_rd.size()), 64'(we ? 0 : nbeats));
      for (int i = 0; !we && i < got_rd.size() && i < nbeats; i++)
         check($sformatf("rdat%0d", i), 64'(got_rd[i]), 64'(e_dat[i]));
      check("idle_after", 64'({cmd_ready, busy, wb_cyc_o, wb_stb_o, done, err}), 64'(6'b100000));
   endtask

   initial begin
      int          len, da;
      logic [31:0] ad;
      bit          wr;

      wb_rst_i = 1'b1;
      drive_idle();
      cmd_we   = 1'b0;
      cmd_addr = '0;
      cmd_len  = 8'd0;
      cmd_sel  = 4'd0;
      #1;
      check("reset_ctrl", 64'({cmd_ready, wdat_ready, rdat_valid, done, err, busy,
                               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'(13'h1000));
      check("reset_adr", 64'(wb_adr_o), 64'(0));
      check("reset_dat", 64'(wb_dat_o), 64'(0));
      check("reset_rdat", 64'(rdat), 64'(0));
      repeat (2) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;

      // Single write beat, ack two cycles after strobe.
      rand_plan(0);
      g_dly[0] = 2; g_stall[0] = 0; g_wd[0] = 32'hA5A5_5A5A;
      run_burst(1'b1, 32'h100, 0, 4'hF, -1, -1);
      // Four-beat read, one wait cycle per beat.
      rand_plan(3);
      for (int i = 0; i < 4; i++) g_dly[i] = 1;
      run_burst(1'b0, 32'h2000, 3, 4'hF, -1, -1);
      // Two-beat write with a 5-cycle stall before the second word.
      rand_plan(1);
      g_dly[0] = 0; g_dly[1] = 0; g_stall[0] = 0; g_stall[1] = 5;
      run_burst(1'b1, 32'h300, 1, 4'b0110, -1, -1);
      rand_plan(1);
      run_burst(1'b0, 32'h300, 1, 4'hF, -1, -1);
      // Read with no ack at all, and a write dying on its second beat.
      rand_plan(2);
      run_burst(1'b0, 32'h400, 2, 4'hF, 0, -1);
      rand_plan(2);
      run_burst(1'b1, 32'h500, 2, 4'hC, 1, -1);
      rand_plan(2);
      run_burst(1'b0, 32'h500, 2, 4'hF, -1, -1);
      // Address wrap at the top of the space.
      rand_plan(1);
      run_burst(1'b0, 32'hFFFF_FFFC, 1, 4'hF, -1, -1);
      // Full-length burst, zero-wait acks.
      rand_plan(255);
      for (int i = 0; i <= 255; i++) g_dly[i] = 0;
      run_burst(1'b0, 32'h8000, 255, 4'hF, -1, -1);

      for (int t = 0; t < 40; t++) begin
         len = ($urandom % 5 == 0) ? int'($urandom_range(8, 24)) : int'($urandom_range(0, 7));
         ad  = 32'h1000 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
         wr  = 1'($urandom);
         da  = ($urandom % 8 == 0) ? int'($urandom_range(0, len)) : -1;
         rand_plan(len);
         run_burst(wr, ad, len, 4'($urandom_range(1, 15)), da, -1);
      end

      // Reset during beat 2 of 4, then the same burst again in full.
      rand_plan(3);
      for (int i = 0; i < 4; i++) g_dly[i] = 1;
      run_burst(1'b0, 32'h2000, 3, 4'hF, -1, 1);
      rand_plan(3);
      run_burst(1'b0, 32'h2000, 3, 4'hF, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone classic-cycle initiator that drives the SDRAM controller's Wishbone slave port (`wb_stb_i`/`wb_cyc_i`/`wb_we_i`/`wb_sel_i` → `wb_ack_o`). It accepts burst commands from a simple valid/ready command port and streams write data in and read data out. It issues one Wishbone beat per word with incrementing addresses, and aborts with an error if the slave fails to acknowledge within a programmable number of cycles. It sits in the `wb_clk_i` domain between test/application logic and the controller.

## Interface
Parameters:
- `AW`, 32: Wishbone byte-address width.
- `TIMEOUT`, 1024: maximum cycles `wb_stb_o` may stay high without `wb_ack_i`. Must be ≥2.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_we` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in AW: start byte address, word aligned (bits [1:0] ignored, forced 0).
- `cmd_len` in 8: beats minus one (0 → 1 beat, 255 → 256 beats).
- `cmd_sel` in 4: byte lanes for every beat.
- `wdat_valid` in 1: write word available.
- `wdat_ready` out 1: write word consumed on `wdat_valid & wdat_ready`.
- `wdat` in 32: write word.
- `rdat_valid` out 1: one-cycle pulse per read beat; no backpressure.
- `rdat` out 32: read word, valid with `rdat_valid`.
- `done` out 1: one-cycle pulse at burst end.
- `err` out 1: one-cycle pulse, coincident with `done`, on timeout abort.
- `busy` out 1: high whenever not IDLE.
- `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_we_o` out 1, `wb_sel_o` out 4, `wb_adr_o` out AW, `wb_dat_o` out 32: Wishbone master outputs.
- `wb_ack_i` in 1, `wb_dat_i` in 32: Wishbone slave responses.

## Operation
- States: IDLE, WDAT, STB, GAP, DONE.
- Reset values: all outputs 0 except `cmd_ready` = 1. `wb_adr_o`, `wb_dat_o` and `rdat` = 0.
- IDLE:
  - `cmd_ready` = 1.
  - On accept, latch `we`, `sel` and `addr & ~3`; load the beat counter with `cmd_len`.
  - Next state is WDAT for a write, STB for a read.
- WDAT:
  - `wb_cyc_o` = 1, `wdat_ready` = 1.
  - On a handshake, register `wdat` into `wb_dat_o` and go to STB.
  - WDAT has no timeout; it waits indefinitely.
- STB:
  - `wb_cyc_o` = `wb_stb_o` = 1; `wb_we_o`, `wb_sel_o`, `wb_adr_o` are held stable.
  - On `wb_ack_i`:
    - Read: `rdat` ← `wb_dat_i` and `rdat_valid` pulses the next cycle.
    - If the counter is 0, go to DONE. Otherwise decrement the counter, add 4 to the address (mod 2^AW) and go to GAP.
- GAP: one cycle with `wb_stb_o` = 0 and `wb_cyc_o` = 1, then WDAT (write) or STB (read).
- Timeout: a counter clears on each entry to STB and increments each STB cycle without ack. When it reaches TIMEOUT−1 without ack, go to DONE with the error flag set; remaining beats are discarded and no further `wdat` is consumed.
- DONE:
  - `wb_cyc_o` = `wb_stb_o` = 0.
  - `done` = 1 and `err` = error flag, for one cycle; then IDLE.
- `wb_ack_i` outside STB is ignored.
- `wb_rst_i` at any point: all outputs return to their reset values immediately, without waiting for a clock edge. In-flight burst data is lost; no `done` is produced.

## Timing
- Command accepted at edge N:
  - Read: `wb_stb_o` high from N+1.
  - Write: `wdat_ready` high from N+1; `wb_stb_o` from N+2 if `wdat_valid` at N+1.
- Ack sampled at edge M:
  - `wb_stb_o` low from M+1.
  - `rdat_valid` high during cycle M+1.
  - Next-beat `wb_stb_o` (read) from M+2.
  - Final beat: `done` high during M+1; `cmd_ready` high from M+2.
- Minimum per-beat period with zero-wait ack: 2 cycles (read), 3 cycles (write).
- Timeout with no ack: `wb_stb_o` high for exactly TIMEOUT cycles, then `done`/`err` are high the next cycle.

## Test plan
- Write: `cmd_addr`=0x100, len 0, `wdat`=0xA5A55A5A ready immediately, ack 2 cycles after stb → one stb beat at 0x100 with `wb_dat_o`=0xA5A55A5A, `wb_we_o`=1; `done`=1, `err`=0; `wdat` consumed exactly once.
- Read: addr 0x2000, len 3, ack every beat after 1 wait cycle → addresses 0x2000/04/08/0C, four `rdat_valid` pulses carrying the slave words in order, a 1-cycle stb gap between beats, a single `done`.
- Write, len 1, `wdat_valid` deasserted 5 cycles before the second word → `wb_stb_o` stays low but `wb_cyc_o` stays high through the stall; second beat issued at 0x...04 after the handshake.
- TIMEOUT=16, read with `wb_ack_i` never asserted → `wb_stb_o` high for 16 cycles, then `done`=`err`=1 for one cycle, `cyc`/`stb` low, IDLE.
- Address wrap: AW=32, addr 0xFFFFFFFC, len 1 read → second beat at 0x00000000.
- `wb_rst_i` pulsed mid-cycle during beat 2 of 4 → `wb_cyc_o`/`wb_stb_o` drop without waiting for a clock edge, no `done`; after reset release `cmd_ready`=1 and a new burst completes normally.
